// File: rtl/ryl19_pkg.sv
// Shared types and constants for the ryl19 PWM stage and its upstream wrap counter.
package ryl19_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_RUN,
        ST_FIN
    } state_e;

endpackage

// File: rtl/ryl19_duty_shadow.sv
// Double-buffered duty register: a new duty is adopted only at a period boundary,
// with a bypass so the boundary cycle itself already uses the new value.
module ryl19_duty_shadow
    import ryl19_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             cnt_done_i,
    input  logic [CNT_W-1:0] duty_in_i,
    output logic [CNT_W-1:0] duty_eff_o
);

    logic [CNT_W-1:0] duty_act_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_act_q <= '0;
        end else if (cnt_done_i || load_i) begin
            duty_act_q <= duty_in_i;
        end
    end

    assign duty_eff_o = cnt_done_i ? duty_in_i : duty_act_q;

endmodule

// File: rtl/ryl19_pwm_stage.sv
// PWM stage: turns counter periods into a PWM waveform, either continuously or for a
// burst of N periods, under a start/stop FSM.
module ryl19_pwm_stage
    import ryl19_pkg::*;
#(
    parameter int BURST_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [CNT_W-1:0]   cnt_q,
    input  logic               cnt_done,
    input  logic [CNT_W-1:0]   duty_in,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               start,
    input  logic               stop,
    output logic               pwm_out,
    output logic               busy,
    output logic               burst_done,
    output logic [BURST_W-1:0] period_cnt
);

    state_e             state_q, state_d;
    logic [BURST_W-1:0] period_cnt_q, period_cnt_d;
    logic               pwm_q, pwm_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   duty_eff;
    logic [BURST_W:0]   period_inc;
    logic               last_period;
    logic               drive;

    ryl19_duty_shadow u_duty_shadow (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (state_q == ST_IDLE),
        .cnt_done_i (cnt_done),
        .duty_in_i  (duty_in),
        .duty_eff_o (duty_eff)
    );

    // Extra bit keeps the burst-length compare exact even when period_cnt is all-ones.
    assign period_inc  = {1'b0, period_cnt_q} + (BURST_W + 1)'(1);
    assign last_period = (burst_len != '0) && (period_inc == {1'b0, burst_len});

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        period_cnt_d = period_cnt_q;
        drive        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d      = ST_ARM;
                    period_cnt_d = '0;
                end
            end
            ST_ARM: begin
                drive = cnt_done;
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (cnt_done) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                drive = !(cnt_done && last_period);
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (cnt_done) begin
                    period_cnt_d = (&period_cnt_q) ? period_cnt_q : period_inc[BURST_W-1:0];
                    if (last_period) begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_ARM) || (state_d == ST_RUN);
        pwm_d  = drive && (cnt_q < duty_eff);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            period_cnt_q <= '0;
            pwm_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_cnt_q <= period_cnt_d;
            pwm_q        <= pwm_d;
            busy_q       <= busy_d;
        end
    end

    assign pwm_out    = pwm_q;
    assign busy       = busy_q;
    assign burst_done = (state_q == ST_FIN);
    assign period_cnt = period_cnt_q;

endmodule

// File: tb/tb_ryl19_pwm_stage.sv
// Self-checking bench for ryl19_pwm_stage: a behavioural wrap counter drives cnt_q/cnt_done,
// expected pwm/busy/burst_done per cycle are queued per scenario and popped after each edge.
module tb_ryl19_pwm_stage;
    import ryl19_pkg::*;

    localparam int BURST_W = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [CNT_W-1:0]   cnt_q;
    logic               cnt_done;
    logic [CNT_W-1:0]   duty_in;
    logic [BURST_W-1:0] burst_len;
    logic               start;
    logic               stop;
    logic               pwm_out;
    logic               busy;
    logic               burst_done;
    logic [BURST_W-1:0] period_cnt;

    typedef struct packed {
        logic pwm;
        logic busy;
        logic bdone;
        logic chk_pwm;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   limit  = 3;
    int   cnt    = 0;

    ryl19_pwm_stage #(.BURST_W(BURST_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cnt_q      (cnt_q),
        .cnt_done   (cnt_done),
        .duty_in    (duty_in),
        .burst_len  (burst_len),
        .start      (start),
        .stop       (stop),
        .pwm_out    (pwm_out),
        .busy       (busy),
        .burst_done (burst_done),
        .period_cnt (period_cnt)
    );

    always #5 clk = ~clk;

    task automatic set_cnt(input int v);
        cnt      = v;
        cnt_q    = CNT_W'(v);
        cnt_done = (limit == 0) || (v == 0);
    endtask

    // One clock: outputs are sampled 1 time unit after the edge, then the counter advances.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        set_cnt((cnt >= limit) ? 0 : cnt + 1);
    endtask

    task automatic push_exp(input logic p, input logic b, input logic d, input logic cp);
        exp_t e;
        e.pwm     = p;
        e.busy    = b;
        e.bdone   = d;
        e.chk_pwm = cp;
        exp_q.push_back(e);
    endtask

    task automatic tick_check(input string name);
        exp_t e;
        tick();
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s cyc=%0d scoreboard empty", name, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.chk_pwm) begin
                checks++;
                if (pwm_out !== e.pwm) begin
                    errors++;
                    $display("FAIL %s cyc=%0d pwm_out got=%b exp=%b", name, cyc, pwm_out, e.pwm);
                end
            end
            checks++;
            if (busy !== e.busy) begin
                errors++;
                $display("FAIL %s cyc=%0d busy got=%b exp=%b", name, cyc, busy, e.busy);
            end
            checks++;
            if (burst_done !== e.bdone) begin
                errors++;
                $display("FAIL %s cyc=%0d burst_done got=%b exp=%b", name, cyc, burst_done, e.bdone);
            end
        end
    endtask

    task automatic test_reset();
        tick();
        checks++;
        if (pwm_out !== 1'b0) begin
            errors++;
            $display("FAIL reset pwm_out got=%b exp=0", pwm_out);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset busy got=%b exp=0", busy);
        end
        checks++;
        if (burst_done !== 1'b0) begin
            errors++;
            $display("FAIL reset burst_done got=%b exp=0", burst_done);
        end
        checks++;
        if (period_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset period_cnt got=%0d exp=0", period_cnt);
        end
    endtask

    // limit=3, duty=2, burst of 2, start one cycle after a period boundary.
    task automatic run_burst(input string name, input logic extra_starts);
        int pw[13] = '{0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0};
        int bz[13] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
        int bd[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        limit     = 3;
        duty_in   = 8'd2;
        burst_len = 4'd2;
        set_cnt(1);
        for (int k = 0; k < 13; k++) push_exp(pw[k] != 0, bz[k] != 0, bd[k] != 0, 1'b1);
        for (int k = 0; k < 13; k++) begin
            start = (k == 0) || (extra_starts && (k == 5 || k == 8));
            tick_check(name);
        end
        start = 1'b0;
        checks++;
        if (period_cnt !== 4'd2) begin
            errors++;
            $display("FAIL %s period_cnt got=%0d exp=2", name, period_cnt);
        end
    endtask

    task automatic test_burst();
        run_burst("burst", 1'b0);
    endtask

    task automatic test_back_to_back();
        run_burst("start_ignored", 1'b1);
        for (int k = 0; k < 3; k++) push_exp(1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            start = (k == 0);
            stop  = (k == 0);
            tick_check("start_stop_idle");
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    // Continuous run: duty 2 -> 3 mid-period, then 0, then 9, ending with stop on cnt_done.
    task automatic test_duty_change();
        int pw[22] = '{0, 0, 0, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0};
        limit     = 3;
        duty_in   = 8'd2;
        burst_len = 4'd0;
        set_cnt(1);
        for (int k = 0; k < 22; k++) push_exp(pw[k] != 0, k < 19, 1'b0, k != 19);
        for (int k = 0; k < 22; k++) begin
            start   = (k == 0);
            stop    = (k == 19);
            duty_in = (k < 4) ? 8'd2 : (k < 11) ? 8'd3 : (k < 15) ? 8'd0 : 8'd9;
            tick_check("duty_change");
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic test_stop();
        int pw[12] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};
        limit     = 3;
        duty_in   = 8'd2;
        burst_len = 4'd2;
        set_cnt(1);
        for (int k = 0; k < 12; k++) push_exp(pw[k] != 0, k < 5, 1'b0, 1'b1);
        for (int k = 0; k < 12; k++) begin
            start = (k == 0);
            stop  = (k == 5);
            tick_check("stop_mid_run");
        end
        start = 1'b0;
        stop  = 1'b0;
        checks++;
        if (period_cnt !== 4'd0) begin
            errors++;
            $display("FAIL stop_mid_run period_cnt got=%0d exp=0", period_cnt);
        end
    endtask

    task automatic test_limit0();
        int pw[7] = '{0, 1, 1, 1, 0, 0, 0};
        int bz[7] = '{1, 1, 1, 1, 0, 0, 0};
        int bd[7] = '{0, 0, 0, 0, 1, 0, 0};
        limit     = 0;
        duty_in   = 8'd1;
        burst_len = 4'd3;
        set_cnt(0);
        for (int k = 0; k < 7; k++) push_exp(pw[k] != 0, bz[k] != 0, bd[k] != 0, 1'b1);
        for (int k = 0; k < 7; k++) begin
            start = (k == 0);
            tick_check("limit0_burst");
        end
        start = 1'b0;
        checks++;
        if (period_cnt !== 4'd3) begin
            errors++;
            $display("FAIL limit0_burst period_cnt got=%0d exp=3", period_cnt);
        end
    endtask

    task automatic test_saturate();
        limit     = 0;
        duty_in   = 8'd1;
        burst_len = 4'd0;
        set_cnt(0);
        for (int k = 0; k < 21; k++) push_exp(k != 0, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 21; k++) begin
            start = (k == 0);
            tick_check("saturate");
        end
        start = 1'b0;
        checks++;
        if (period_cnt !== 4'd15) begin
            errors++;
            $display("FAIL saturate period_cnt got=%0d exp=15", period_cnt);
        end
        push_exp(1'b0, 1'b0, 1'b0, 1'b0);
        push_exp(1'b0, 1'b0, 1'b0, 1'b1);
        stop = 1'b1;
        tick_check("saturate_stop");
        stop = 1'b0;
        tick_check("saturate_stop");
    endtask

    task automatic test_async_reset();
        int pw[8] = '{0, 0, 0, 1, 1, 1, 1, 1};
        limit     = 3;
        duty_in   = 8'd9;
        burst_len = 4'd0;
        set_cnt(1);
        for (int k = 0; k < 8; k++) push_exp(pw[k] != 0, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            start = (k == 0);
            tick_check("pre_reset_run");
        end
        start = 1'b0;
        checks++;
        if (period_cnt !== 4'd1) begin
            errors++;
            $display("FAIL pre_reset_run period_cnt got=%0d exp=1", period_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (pwm_out !== 1'b0) begin
            errors++;
            $display("FAIL async_reset pwm_out got=%b exp=0", pwm_out);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset busy got=%b exp=0", busy);
        end
        checks++;
        if (period_cnt !== 4'd0) begin
            errors++;
            $display("FAIL async_reset period_cnt got=%0d exp=0", period_cnt);
        end
        #3;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) push_exp(1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) tick_check("post_reset_idle");
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        duty_in   = '0;
        burst_len = '0;
        limit     = 3;
        set_cnt(0);
        #22;
        rst_n = 1'b1;

        test_reset();
        test_burst();
        test_back_to_back();
        test_duty_change();
        test_stop();
        test_limit0();
        test_saturate();
        test_async_reset();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain leftover=%0d exp=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
